mtr_ramp_ctrl: RTL and testbench



---
 rtl/mtr_ramp_ctrl.sv | 142 ++++++++++++++
 tb/tb_mtr_ramp_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mtr_ramp_ctrl.sv
// Slew-rate limiter for signed left/right wheel speed commands feeding the motor driver.
// Latency: accept->RAMP 1 cycle, first step after TICK_DIV cycles; estop zeroes outputs next cycle.
// Backpressure: cmd_rdy high only in IDLE with estop/rst low; no command queueing while ramping.
// Optional target saturation to +/-MAX_SPD when MTR_RAMP_CLAMP_EN is defined.
`timescale 1ns/1ps

module mtr_ramp_ctrl #(
  parameter int STEP     = 8,
  parameter int TICK_DIV = 1024,
  parameter int MAX_SPD  = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_vld,
  input  logic signed [10:0] cmd_lft,
  input  logic signed [10:0] cmd_rght,
  output logic               cmd_rdy,
  input  logic               estop,
  output logic signed [10:0] lft_spd,
  output logic signed [10:0] rght_spd,
  output logic               busy,
  output logic               at_target
);

  localparam int              CW        = $clog2(TICK_DIV);
  localparam logic [CW-1:0]   TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic signed [11:0] STEP_S = 12'(STEP);

  typedef enum logic [1:0] {IDLE, RAMP, ESTOP} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        tick_cnt;
  logic signed [10:0]   tgt_lft, tgt_rght;
  logic signed [10:0]   lim_lft, lim_rght;
  logic signed [10:0]   lft_step, rght_step;
  logic                 accept, tick_end, same, done, at_nxt;

  // Move cur one STEP toward tgt; 12-bit difference cannot overflow for 11-bit operands.
  function automatic logic signed [10:0] step_to(input logic signed [10:0] cur,
                                                 input logic signed [10:0] tgt);
    logic signed [11:0] d, mag, sum;
    d   = {tgt[10], tgt} - {cur[10], cur};
    mag = d[11] ? -d : d;
    sum = d[11] ? ({cur[10], cur} - STEP_S) : ({cur[10], cur} + STEP_S);
    if (mag <= STEP_S) step_to = tgt;
    else               step_to = 11'(sum);
  endfunction

`ifdef MTR_RAMP_CLAMP_EN
  localparam logic signed [11:0] MAX_S = 12'(MAX_SPD);

  // Saturate a commanded target into [-MAX_SPD, +MAX_SPD].
  function automatic logic signed [10:0] limit(input logic signed [10:0] v);
    logic signed [11:0] w;
    w = {v[10], v};
    if (w > MAX_S)       limit = 11'(MAX_S);
    else if (w < -MAX_S) limit = 11'(-MAX_S);
    else                 limit = v;
  endfunction
`else
  localparam int unused_max_spd = MAX_SPD;

  // Full 11-bit range passes through untouched.
  function automatic logic signed [10:0] limit(input logic signed [10:0] v);
    limit = v;
  endfunction
`endif

  // Next-state, handshake and at_target decode; estop overrides every state.
  always_comb begin
    state_nxt = state;
    cmd_rdy   = 1'b0;
    accept    = 1'b0;
    at_nxt    = 1'b0;
    lim_lft   = limit(cmd_lft);
    lim_rght  = limit(cmd_rght);
    lft_step  = step_to(lft_spd, tgt_lft);
    rght_step = step_to(rght_spd, tgt_rght);
    tick_end  = (tick_cnt == TICK_LAST);
    same      = (lim_lft == lft_spd) && (lim_rght == rght_spd);
    done      = (lft_step == tgt_lft) && (rght_step == tgt_rght);
    case (state)
      IDLE: begin
        cmd_rdy = !rst && !estop;
        accept  = cmd_vld && cmd_rdy;
        if (accept) begin
          if (same) at_nxt    = 1'b1;
          else      state_nxt = RAMP;
        end
      end
      RAMP: begin
        if (tick_end && done) begin
          state_nxt = IDLE;
          at_nxt    = 1'b1;
        end
      end
      ESTOP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (estop) begin
      state_nxt = ESTOP;
      at_nxt    = 1'b0;
    end
  end

  // State register; busy is registered alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // Targets, tick counter and speed outputs.
  always_ff @(posedge clk) begin
    if (rst || estop) begin
      lft_spd   <= '0;
      rght_spd  <= '0;
      tgt_lft   <= '0;
      tgt_rght  <= '0;
      tick_cnt  <= '0;
      at_target <= 1'b0;
    end else begin
      at_target <= at_nxt;
      if (accept) begin
        tgt_lft  <= lim_lft;
        tgt_rght <= lim_rght;
        tick_cnt <= '0;
      end else if (state == RAMP) begin
        tick_cnt <= tick_end ? '0 : tick_cnt + 1'b1;
        if (tick_end) begin
          lft_spd  <= lft_step;
          rght_spd <= rght_step;
        end
      end
    end
  end

endmodule

// File: tb/tb_mtr_ramp_ctrl.sv
// Bench for mtr_ramp_ctrl with STEP=8, TICK_DIV=4.
// Vectors drive one cycle each; cmd_rdy checked within the cycle, registered outputs after the edge.
// Expected registered outputs go through a scoreboard queue.
`timescale 1ns/1ps

module tb_mtr_ramp_ctrl;
  localparam int STEP     = 8;
  localparam int TICK_DIV = 4;

`ifdef MTR_RAMP_CLAMP_EN
  localparam int LIM_P = 1000;
  localparam int LIM_N = -1000;
`else
  localparam int LIM_P = 1023;
  localparam int LIM_N = -1024;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cmd_vld = 1'b0;
  logic signed [10:0] cmd_lft = '0;
  logic signed [10:0] cmd_rght = '0;
  logic               estop = 1'b0;
  logic               cmd_rdy, busy, at_target;
  logic signed [10:0] lft_spd, rght_spd;

  always #5 clk = ~clk;

  mtr_ramp_ctrl #(.STEP(STEP), .TICK_DIV(TICK_DIV), .MAX_SPD(1000)) dut (
    .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_lft(cmd_lft), .cmd_rght(cmd_rght),
    .cmd_rdy(cmd_rdy), .estop(estop), .lft_spd(lft_spd), .rght_spd(rght_spd),
    .busy(busy), .at_target(at_target)
  );

  typedef struct {
    logic               rst, vld, estop;
    logic signed [10:0] l, r;
    logic               e_rdy;
    logic signed [10:0] e_lft, e_rght;
    logic               e_busy, e_at;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  vec_t sb[$];
  vec_t tbl[12];

  function automatic vec_t mk(input int rs, input int vld, input int l, input int r,
                              input int es, input int rdy, input int el, input int er,
                              input int bz, input int at);
    vec_t v;
    v.rst = rs[0]; v.vld = vld[0]; v.l = 11'(l); v.r = 11'(r); v.estop = es[0];
    v.e_rdy = rdy[0]; v.e_lft = 11'(el); v.e_rght = 11'(er);
    v.e_busy = bz[0]; v.e_at = at[0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    rst = v.rst; cmd_vld = v.vld; cmd_lft = v.l; cmd_rght = v.r; estop = v.estop;
    #1;
    chk({tag, " cmd_rdy"}, {31'd0, cmd_rdy}, {31'd0, v.e_rdy});
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, " lft_spd"}, lft_spd, e.e_lft);
    chk({tag, " rght_spd"}, rght_spd, e.e_rght);
    chk({tag, " busy"}, {31'd0, busy}, {31'd0, e.e_busy});
    chk({tag, " at_target"}, {31'd0, at_target}, {31'd0, e.e_at});
  endtask

  // Speed after n ticks when ramping from 0 toward t.
  function automatic int exp_spd(input int t, input int n);
    int m, s;
    m = (t < 0) ? -t : t;
    s = STEP * n;
    if (s > m) s = m;
    return (t < 0) ? -s : s;
  endfunction

  // Command (cl,cr) from speed 0 whose effective targets are (tl,tr); run up to 'stop'
  // cycles after accept, optionally pulsing a stray (-100,-100) command at cycle 'inject'.
  task automatic ramp_run(input int cl, input int cr, input int tl, input int tr,
                          input int stop, input int inject, input string tag);
    int m, ncyc, last, n;
    m    = (tl < 0) ? -tl : tl;
    if (((tr < 0) ? -tr : tr) > m) m = (tr < 0) ? -tr : tr;
    ncyc = ((m + STEP - 1) / STEP) * TICK_DIV;
    last = (stop < ncyc) ? stop : ncyc;
    apply(mk(0, 1, cl, cr, 0, 1, 0, 0, 1, 0), {tag, " accept"});
    for (int k = 1; k <= last; k++) begin
      n = k / TICK_DIV;
      apply(mk(0, (k == inject) ? 1 : 0, -100, -100, 0, 0,
               exp_spd(tl, n), exp_spd(tr, n), (k < ncyc) ? 1 : 0, (k == ncyc) ? 1 : 0),
            $sformatf("%s c%0d", tag, k));
    end
  endtask

  initial begin
    // rst vld l r estop | rdy lft rght busy at
    tbl[0]  = mk(1, 0, 0, 0, 0,    0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0,    0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0,    1, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0, 0,    1, 0, 0, 0, 1);
    tbl[4]  = mk(0, 0, 0, 0, 0,    1, 0, 0, 0, 0);
    tbl[5]  = mk(0, 1, 5, 5, 1,    0, 0, 0, 1, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0,    0, 0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0,    1, 0, 0, 0, 0);
    tbl[8]  = mk(0, 1, 60, 60, 1,  0, 0, 0, 1, 0);
    tbl[9]  = mk(0, 0, 0, 0, 1,    0, 0, 0, 1, 0);
    tbl[10] = mk(0, 0, 0, 0, 0,    0, 0, 0, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 0,    1, 0, 0, 0, 0);

    // Reset, same-target command, estop in IDLE discarding a handshake.
    for (int i = 0; i <= 7; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Ramp up to (+40,+40) with a stray command mid-ramp that must be ignored.
    ramp_run(40, 40, 40, 40, 1000, 6, "up40");
    apply(mk(0, 0, 0, 0, 0, 1, 40, 40, 0, 0), "up40 idle");

    // Non-multiple targets with opposite signs.
    apply(tbl[0], "rst2");
    ramp_run(20, -13, 20, -13, 1000, 0, "mixed");
    apply(mk(0, 0, 0, 0, 0, 1, 20, -13, 0, 0), "mixed idle");

    // Estop at (+24,+24) while ramping to 40.
    apply(tbl[0], "rst3");
    ramp_run(40, 40, 40, 40, 12, 0, "pre_estop");
    for (int i = 8; i <= 11; i++) apply(tbl[i], $sformatf("tbl%0d", i));
    for (int i = 0; i < 6; i++) apply(tbl[11], $sformatf("post_estop%0d", i));

    // Full-scale command; saturated when the clamp is built in.
    ramp_run(1023, -1024, LIM_P, LIM_N, 100000, 0, "full");
    apply(mk(0, 0, 0, 0, 0, 1, LIM_P, LIM_N, 0, 0), "full idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
